// File: rtl/imem_loader.sv
// Instruction memory writer: assembles a big-endian host byte stream into 32-bit words
// and writes them sequentially, stalling fetch while loading. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        hold_fetch,
    output logic        load_done,
    output logic        load_err,
    output logic [10:0] word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam int unsigned CNT_W = 11;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      word_q, word_d;
    logic             byte_ready_q, byte_ready_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_waddr_q, mem_waddr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             hold_fetch_q, hold_fetch_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic             accept;
    logic [31:0]      assembled;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      checksum_q, checksum_d;
`endif

    // Next-state, byte assembly and registered-output computation
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        accept = byte_valid & byte_ready_q;

        // A fresh word starts from zero so a short final word comes out zero-padded
        assembled = (idx_q == 2'd0) ? 32'd0 : word_q;
        unique case (idx_q)
            2'd0:    assembled[31:24] = byte_data;
            2'd1:    assembled[23:16] = byte_data;
            2'd2:    assembled[15:8]  = byte_data;
            default: assembled[7:0]   = byte_data;
        endcase

        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (word_count_q == DEPTH_C) begin
                        state_d = ERR;
                    end else begin
                        word_d = assembled;
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3 || byte_last) begin
                            mem_we_d     = 1'b1;
                            mem_wdata_d  = assembled;
                            mem_waddr_d  = BASE_ADDR + {19'd0, word_count_q, 2'b00};
                            word_count_d = word_count_q + CNT_W'(1);
                            idx_d        = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            checksum_d   = checksum_q + assembled;
`endif
                            if (byte_last) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            default: begin
                if (load_start) begin
                    state_d      = LOAD;
                    idx_d        = 2'd0;
                    word_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    checksum_d   = 32'd0;
`endif
                end
            end
        endcase

        byte_ready_d = (state_d == LOAD);
        hold_fetch_d = (state_d == LOAD) || (state_d == ERR);
        load_done_d  = (state_d == DONE);
        load_err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            word_q       <= 32'd0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= 32'd0;
            mem_wdata_q  <= 32'd0;
            hold_fetch_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            word_count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_q   <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            hold_fetch_q <= hold_fetch_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            word_count_q <= word_count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hold_fetch = hold_fetch_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (default config and DEPTH=2/BASE=0x100) checked
// against an image-level model of expected words, addresses and write timing.
module tb_imem_loader;

    localparam int unsigned DEPTH1 = 2;
    localparam logic [31:0] BASE1  = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      load_start, byte_valid, byte_last;
    logic [1:0][7:0] byte_data;

    wire        br0, br1, we0, we1, hf0, hf1, ld0, ld1, le0, le1;
    wire [31:0] wa0, wa1, wd0, wd1;
    wire [10:0] wc0, wc1;
    wire [1:0]  byte_ready = {br1, br0};
    wire [1:0]  mem_we     = {we1, we0};
    wire [1:0]  hold_fetch = {hf1, hf0};
    wire [1:0]  load_done  = {ld1, ld0};
    wire [1:0]  load_err   = {le1, le0};
    wire [1:0][31:0] mem_waddr  = {wa1, wa0};
    wire [1:0][31:0] mem_wdata  = {wd1, wd0};
    wire [1:0][10:0] word_count = {wc1, wc0};
`ifdef IMEM_LOADER_CHECKSUM_EN
    wire [31:0] cs0, cs1;
    wire [1:0][31:0] checksum = {cs1, cs0};
`endif

    imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .clk(clk), .rst(rst), .load_start(load_start[0]), .byte_valid(byte_valid[0]),
        .byte_data(byte_data[0]), .byte_last(byte_last[0]), .byte_ready(br0), .mem_we(we0),
        .mem_waddr(wa0), .mem_wdata(wd0), .hold_fetch(hf0), .load_done(ld0), .load_err(le0),
        .word_count(wc0)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cs0)
`endif
    );

    imem_loader #(.DEPTH(DEPTH1), .BASE_ADDR(BASE1)) u_dut1 (
        .clk(clk), .rst(rst), .load_start(load_start[1]), .byte_valid(byte_valid[1]),
        .byte_data(byte_data[1]), .byte_last(byte_last[1]), .byte_ready(br1), .mem_we(we1),
        .mem_waddr(wa1), .mem_wdata(wd1), .hold_fetch(hf1), .load_done(ld1), .load_err(le1),
        .word_count(wc1)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .checksum(cs1)
`endif
    );

    logic [7:0] img [0:63];
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 1024 : int'(DEPTH1);
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'd0 : BASE1;
    endfunction

    // Word k of an n-byte image: big-endian, missing tail bytes are zero
    function automatic logic [31:0] model_word(input int k, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 4; j++)
            if (4 * k + j < n) w[31 - 8 * j -: 8] = img[4 * k + j];
        return w;
    endfunction

    task automatic check_reset(input int d);
        check_val("rst_byte_ready", 32'(byte_ready[d]), 32'd0);
        check_val("rst_mem_we",     32'(mem_we[d]),     32'd0);
        check_val("rst_mem_waddr",  mem_waddr[d],       32'd0);
        check_val("rst_mem_wdata",  mem_wdata[d],       32'd0);
        check_val("rst_hold_fetch", 32'(hold_fetch[d]), 32'd0);
        check_val("rst_load_done",  32'(load_done[d]),  32'd0);
        check_val("rst_load_err",   32'(load_err[d]),   32'd0);
        check_val("rst_word_count", 32'(word_count[d]), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_val("rst_checksum",   checksum[d],        32'd0);
`endif
    endtask

    task automatic start_load(input int d);
        load_start[d] = 1'b1;
        @(negedge clk);
        load_start[d] = 1'b0;
        check_val("start_hold_fetch", 32'(hold_fetch[d]), 32'd1);
        check_val("start_load_done",  32'(load_done[d]),  32'd0);
        check_val("start_load_err",   32'(load_err[d]),   32'd0);
        check_val("start_word_count", 32'(word_count[d]), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_val("start_checksum",   checksum[d],        32'd0);
`endif
    endtask

    // Stream img[0..n-1]; mode 0 back-to-back, 1 alternate cycles, 2 random valid
    task automatic run_load(input int d, input int n, input bit use_last, input int mode,
                            output logic [31:0] sum);
        int  acc, cyc, k, dep;
        bit  fin, v, exp_we;
        acc = 0; cyc = 0; k = 0; fin = 1'b0; sum = 32'd0;
        dep = depth_of(d);
        while (!fin) begin
            check_val("byte_ready", 32'(byte_ready[d]), 32'd1);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid[d] = v;
            byte_data[d]  = v ? img[acc] : 8'($urandom);
            byte_last[d]  = v ? (use_last && acc == n - 1) : 1'($urandom_range(0, 1));
            exp_we = 1'b0;
            if (v) begin
                if (acc >= 4 * dep) begin
                    fin = 1'b1;
                end else begin
                    if (acc % 4 == 3 || (use_last && acc == n - 1)) begin
                        exp_we = 1'b1;
                        k = acc / 4;
                    end
                    acc++;
                    if (acc == n || (use_last && acc == n)) fin = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
            check_val("mem_we", 32'(mem_we[d]), 32'(exp_we));
            if (exp_we) begin
                check_val("mem_waddr",  mem_waddr[d], base_of(d) + 32'(4 * k));
                check_val("mem_wdata",  mem_wdata[d], model_word(k, n));
                check_val("word_count", 32'(word_count[d]), 32'(k + 1));
                sum = sum + model_word(k, n);
            end
            if (cyc > 2000) begin
                check_val("load_timeout", 32'(cyc), 32'd0);
                fin = 1'b1;
            end
        end
        byte_valid[d] = 1'b0;
        byte_last[d]  = 1'b0;
    endtask

    task automatic check_end(input int d, input bit done, input int nwords, input logic [31:0] sum);
        check_val("end_load_done",  32'(load_done[d]),  32'(done));
        check_val("end_load_err",   32'(load_err[d]),   32'(!done));
        check_val("end_hold_fetch", 32'(hold_fetch[d]), 32'(!done));
        check_val("end_byte_ready", 32'(byte_ready[d]), 32'd0);
        check_val("end_word_count", 32'(word_count[d]), 32'(nwords));
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_val("end_checksum",   checksum[d],        sum);
`endif
        $display("load d=%0d words=%0d sum=%h", d, nwords, sum);
    endtask

    initial begin
        logic [31:0] sum;
        int          n, d, dep;
        bit          done;

        rst = 1'b1; load_start = '0; byte_valid = '0; byte_last = '0; byte_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        check_reset(1);

        // Full word with last on the 4th byte
        img[0] = 8'h3C; img[1] = 8'h01; img[2] = 8'h10; img[3] = 8'h00;
        start_load(0);
        run_load(0, 4, 1'b1, 0, sum);
        check_val("full_wdata", mem_wdata[0], 32'h3C01_1000);
        check_end(0, 1'b1, 1, 32'h3C01_1000);

        // Partial final word is zero-padded
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44; img[4] = 8'h55; img[5] = 8'h66;
        start_load(0);
        run_load(0, 6, 1'b1, 0, sum);
        check_val("partial_wdata", mem_wdata[0], 32'h5566_0000);
        check_end(0, 1'b1, 2, 32'h1122_3344 + 32'h5566_0000);

        // Throttled stream on the offset-base instance
        for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
        start_load(1);
        run_load(1, 8, 1'b1, 1, sum);
        check_end(1, 1'b1, 2, sum);

        // Overflow: 9th byte into a 2-word memory
        for (int i = 0; i < 9; i++) img[i] = 8'($urandom);
        start_load(1);
        run_load(1, 9, 1'b0, 0, sum);
        check_end(1, 1'b0, 2, sum);
        for (int i = 0; i < 3; i++) begin
            byte_valid[1] = 1'b1;
            byte_last[1]  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("err_no_write", 32'(mem_we[1]), 32'd0);
            check_val("err_held",     32'(load_err[1]), 32'd1);
        end
        byte_valid[1] = 1'b0; byte_last[1] = 1'b0;
        start_load(1);
        for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
        run_load(1, 4, 1'b1, 0, sum);
        check_end(1, 1'b1, 1, sum);

        // Reset mid-load abandons the partial word
        for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
        start_load(0);
        run_load(0, 2, 1'b0, 0, sum);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        check_reset(1);
        start_load(0);
        run_load(0, 4, 1'b1, 0, sum);
        check_end(0, 1'b1, 1, sum);

        // Random images with random valid gaps on both instances
        for (int it = 0; it < 12; it++) begin
            d   = it % 2;
            dep = depth_of(d);
            n   = (d == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) img[i] = 8'($urandom);
            start_load(d);
            run_load(d, n, 1'b1, 2, sum);
            done = (n <= 4 * dep);
            check_end(d, done, done ? (n + 3) / 4 : dep, sum);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum wraps modulo 2^32
        img[0] = 8'hFF; img[1] = 8'hFF; img[2] = 8'hFF; img[3] = 8'hFF;
        img[4] = 8'h00; img[5] = 8'h00; img[6] = 8'h00; img[7] = 8'h02;
        start_load(0);
        run_load(0, 8, 1'b1, 0, sum);
        check_val("checksum_wrap", checksum[0], 32'h0000_0001);
        check_end(0, 1'b1, 2, sum);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
